// File: rtl/hf_conf_pkg.sv
// Shared constants and types for the SPI configuration receiver.
// Mode encodings, opcode numbering and the mode-switch FSM states.
package hf_conf_pkg;

    localparam logic [2:0] MODE_OFF     = 3'b111;
    localparam logic [7:0] REG0_RST     = 8'hE0;
    localparam int         OPC_WR_FIRST = 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_GUARD = 2'd1,
        ST_APPLY = 2'd2
    } mode_st_e;

    // Opcodes 1..num_regs write a register; the next one selects the readback register.
    function automatic int rd_opcode(input int num_regs);
        return OPC_WR_FIRST + num_regs;
    endfunction

    function automatic logic [2:0] req_mode(input logic [7:0] reg0);
        return reg0[7:5];
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with edge pulses.
// Output lags the pin by STAGES cycles; rise/fall pulses last one cycle.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d_i);
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/hf_conf_rx.sv
// SPI-written configuration register file with guarded major-mode switching.
// Writes land one cycle after the synced ncs rising edge; no backpressure on SPI.
module hf_conf_rx
    import hf_conf_pkg::*;
#(
    parameter int WORD_W       = 16,
    parameter int OPC_W        = 4,
    parameter int NUM_REGS     = 4,
    parameter int GUARD_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  ck_1356meg,
    input  logic                  nrst,
    input  logic                  spck,
    input  logic                  mosi,
    input  logic                  ncs,
    output logic                  miso,
    output logic [NUM_REGS*8-1:0] conf_word,
    output logic [2:0]            major_mode,
    output logic                  mode_valid,
    output logic                  cmd_strobe,
    output logic                  frame_err
);

    localparam int CNT_W = $clog2(WORD_W + 2);
    localparam int SEL_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int GW    = $clog2(GUARD_CYCLES + 1);
    localparam int RD_OPC = rd_opcode(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_W + 1);
    localparam logic [GW-1:0]    GLOAD    = GW'(GUARD_CYCLES - 1);

    logic spck_s, spck_rise, spck_fall;
    logic mosi_s;
    logic ncs_s, ncs_rise, ncs_fall;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_spck (
        .clk_i  (ck_1356meg),
        .rst_ni (nrst),
        .d_i    (spck),
        .q_o    (spck_s),
        .rise_o (spck_rise),
        .fall_o (spck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i  (ck_1356meg),
        .rst_ni (nrst),
        .d_i    (mosi),
        .q_o    (mosi_s),
        .rise_o (),
        .fall_o ()
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk_i  (ck_1356meg),
        .rst_ni (nrst),
        .d_i    (ncs),
        .q_o    (ncs_s),
        .rise_o (ncs_rise),
        .fall_o (ncs_fall)
    );

    // ------------------------------------------------------------------
    // SPI frame receive, decode and readback
    // ------------------------------------------------------------------
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
    logic [WORD_W-1:0]      rb_q, rb_d;
    logic [SEL_W-1:0]       rd_sel_q, rd_sel_d;
    logic [7:0]             regs_q [NUM_REGS];
    logic [7:0]             regs_d [NUM_REGS];
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic                   armed_q, armed_d;
    logic                   strobe_q, strobe_d;
    logic                   ferr_q, ferr_d;

    logic [OPC_W-1:0] opc;
    int               opc_i;
    logic             frame_ok;
    logic             wr_en;
    logic             sel_en;

    assign opc      = shift_q[WORD_W-1 -: OPC_W];
    assign opc_i    = int'(opc);
    assign frame_ok = armed_q & ncs_rise & (bitcnt_q == CNT_FULL);
    assign wr_en    = frame_ok && (opc_i >= OPC_WR_FIRST) && (opc_i <= NUM_REGS);
    assign sel_en   = frame_ok && (opc_i == RD_OPC);

    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        rb_d     = rb_q;
        rd_sel_d = rd_sel_q;
        regs_d   = regs_q;
        prime_d  = (prime_q << 1) | SYNC_STAGES'(1);
        // Once the ncs synchroniser has refilled after reset, an idle-high ncs
        // counts as the deasserting edge; a frame caught mid-way stays ignored.
        armed_d  = armed_q | (prime_q[SYNC_STAGES-1] & ncs_s);
        strobe_d = 1'b0;
        ferr_d   = 1'b0;

        if (ncs_fall) begin
            bitcnt_d = '0;
            rb_d     = {regs_q[rd_sel_q], {(WORD_W-8){1'b0}}};
        end else if (armed_q && !ncs_s) begin
            if (spck_rise) begin
                shift_d = {shift_q[WORD_W-2:0], mosi_s};
                if (bitcnt_q != CNT_MAX) begin
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                end
            end
            if (spck_fall) begin
                rb_d = rb_q << 1;
            end
        end

        if (armed_q && ncs_rise && !frame_ok) begin
            ferr_d = 1'b1;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && (opc_i == i + OPC_WR_FIRST)) begin
                regs_d[i] = shift_q[7:0];
            end
        end
        if (sel_en) begin
            rd_sel_d = shift_q[SEL_W-1:0];
        end
        strobe_d = wr_en | sel_en;
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            rb_q     <= '0;
            rd_sel_q <= '0;
            prime_q  <= '0;
            armed_q  <= 1'b0;
            strobe_q <= 1'b0;
            ferr_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (i == 0) ? REG0_RST : 8'h00;
            end
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            rb_q     <= rb_d;
            rd_sel_q <= rd_sel_d;
            prime_q  <= prime_d;
            armed_q  <= armed_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
            regs_q   <= regs_d;
        end
    end

    always_comb begin
        conf_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            conf_word[8*i +: 8] = regs_q[i];
        end
    end

    assign miso       = rb_q[WORD_W-1] & ~ncs_s;
    assign cmd_strobe = strobe_q;
    assign frame_err  = ferr_q;

    // ------------------------------------------------------------------
    // Mode switch: every change passes through OFF for the guard period
    // ------------------------------------------------------------------
    mode_st_e      state_q, state_d;
    logic [2:0]    major_q, major_d;
    logic [2:0]    req_q;
    logic [2:0]    req;
    logic          valid_q, valid_d;
    logic [GW-1:0] gcnt_q, gcnt_d;

    assign req = req_mode(regs_q[0]);

    always_comb begin
        state_d = state_q;
        major_d = major_q;
        valid_d = valid_q;
        gcnt_d  = gcnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (req != major_q) begin
                    state_d = ST_GUARD;
                    major_d = MODE_OFF;
                    valid_d = 1'b0;
                    gcnt_d  = GLOAD;
                end
            end
            ST_GUARD: begin
                if (req != req_q) begin
                    gcnt_d = GLOAD;
                end else if (gcnt_q == '0) begin
                    state_d = ST_APPLY;
                end else begin
                    gcnt_d = gcnt_q - GW'(1);
                end
            end
            ST_APPLY: begin
                major_d = req;
                valid_d = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nrst) begin
            state_q <= ST_RUN;
            major_q <= MODE_OFF;
            valid_q <= 1'b1;
            gcnt_q  <= '0;
            req_q   <= MODE_OFF;
        end else begin
            state_q <= state_d;
            major_q <= major_d;
            valid_q <= valid_d;
            gcnt_q  <= gcnt_d;
            req_q   <= req;
        end
    end

    assign major_mode = major_q;
    assign mode_valid = valid_q;

endmodule

// File: tb/tb_hf_conf_rx.sv
// Directed bench for hf_conf_rx: SPI frames driven at 8 clocks per bit.
// Guard period is lengthened so a second frame can land inside it.
module tb_hf_conf_rx;

    localparam int G = 200;

    logic        clk = 1'b0;
    logic        nrst, spck, mosi, ncs;
    logic        miso;
    logic [31:0] conf_word;
    logic [2:0]  major_mode;
    logic        mode_valid, cmd_strobe, frame_err;

    hf_conf_rx #(
        .WORD_W(16), .OPC_W(4), .NUM_REGS(4), .GUARD_CYCLES(G), .SYNC_STAGES(2)
    ) dut (
        .ck_1356meg (clk),
        .nrst       (nrst),
        .spck       (spck),
        .mosi       (mosi),
        .ncs        (ncs),
        .miso       (miso),
        .conf_word  (conf_word),
        .major_mode (major_mode),
        .mode_valid (mode_valid),
        .cmd_strobe (cmd_strobe),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    int         cyc = 0;
    int         n_strobe = 0, n_ferr = 0, n_vlow = 0;
    int         strobe_cyc = -1, chg_cyc = -1;
    logic [2:0] prev_major = 3'b111;
    logic       seen_001 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_strobe === 1'b1) begin
            n_strobe   = n_strobe + 1;
            strobe_cyc = cyc;
        end
        if (frame_err === 1'b1) n_ferr = n_ferr + 1;
        if (mode_valid !== 1'b1) n_vlow = n_vlow + 1;
        if (major_mode !== prev_major) begin
            chg_cyc    = cyc;
            prev_major = major_mode;
        end
        if (major_mode === 3'b001) seen_001 = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] word, input int nbits, output logic [31:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = word[i];
            clk_n(4);
            rx   = {rx[30:0], miso};
            spck = 1'b1;
            clk_n(4);
            spck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits, output logic [31:0] rx);
        ncs = 1'b0;
        clk_n(4);
        shift_bits(word, nbits, rx);
        clk_n(4);
        ncs  = 1'b1;
        mosi = 1'b0;
        clk_n(8);
    endtask

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          d_strobe;
        int          d_err;
        logic [31:0] conf;
        logic        chk_rx;
        logic [15:0] rx;
    } vec_t;

    initial begin
        vec_t        vt [8];
        logic [31:0] rx;
        int          s0, e0, v0, s1, s2;

        // Rows run after mode 010 is established (conf 0x00000040).
        vt[0] = '{32'h0000_2011, 15, 0, 1, 32'h0000_0040, 1'b0, 16'h0000};
        vt[1] = '{32'h0001_2011, 17, 0, 1, 32'h0000_0040, 1'b0, 16'h0000};
        vt[2] = '{32'h0000_3055, 16, 1, 0, 32'h0055_0040, 1'b0, 16'h0000};
        vt[3] = '{32'h0000_5002, 16, 1, 0, 32'h0055_0040, 1'b0, 16'h0000};
        vt[4] = '{32'h0000_0000, 16, 0, 0, 32'h0055_0040, 1'b1, 16'h5500};
        vt[5] = '{32'h0000_6123, 16, 0, 0, 32'h0055_0040, 1'b0, 16'h0000};
        vt[6] = '{32'h0000_4099, 16, 1, 0, 32'h9955_0040, 1'b0, 16'h0000};
        vt[7] = '{32'h0000_104F, 16, 1, 0, 32'h9955_004F, 1'b0, 16'h0000};

        nrst = 1'b0; ncs = 1'b1; spck = 1'b0; mosi = 1'b0;
        clk_n(3);
        nrst = 1'b1;
        clk_n(6);

        check("rst conf_word", conf_word, 32'h0000_00E0);
        check("rst major_mode", 32'(major_mode), 32'h7);
        check("rst mode_valid", 32'(mode_valid), 32'h1);
        check("rst cmd_strobe", 32'(cmd_strobe), 32'h0);
        check("rst frame_err", 32'(frame_err), 32'h0);
        check("rst miso", 32'(miso), 32'h0);

        // Writing OFF while already OFF: no guard excursion.
        s0 = n_strobe; v0 = n_vlow;
        send_frame(32'h10E3, 16, rx);
        clk_n(20);
        check("off-write strobe", 32'(n_strobe - s0), 32'd1);
        check("off-write conf", conf_word, 32'h0000_00E3);
        check("off-write major", 32'(major_mode), 32'h7);
        check("off-write valid_low", 32'(n_vlow - v0), 32'd0);

        // Mode 010: RUN detect cycle, G guard cycles, APPLY cycle.
        s0 = n_strobe; v0 = n_vlow; chg_cyc = -1;
        send_frame(32'h1040, 16, rx);
        clk_n(G + 20);
        check("m010 strobe", 32'(n_strobe - s0), 32'd1);
        check("m010 conf", conf_word, 32'h0000_0040);
        check("m010 latency", 32'(chg_cyc - strobe_cyc), 32'(G + 2));
        check("m010 major", 32'(major_mode), 32'h2);
        check("m010 valid", 32'(mode_valid), 32'h1);
        check("m010 valid_low", 32'(n_vlow - v0), 32'(G + 1));

        for (int r = 0; r < 8; r++) begin
            s0 = n_strobe; e0 = n_ferr; v0 = n_vlow;
            send_frame(vt[r].word, vt[r].nbits, rx);
            clk_n(10);
            check($sformatf("row%0d strobe", r), 32'(n_strobe - s0), 32'(vt[r].d_strobe));
            check($sformatf("row%0d frame_err", r), 32'(n_ferr - e0), 32'(vt[r].d_err));
            check($sformatf("row%0d conf", r), conf_word, vt[r].conf);
            check($sformatf("row%0d major", r), 32'(major_mode), 32'h2);
            check($sformatf("row%0d valid_low", r), 32'(n_vlow - v0), 32'd0);
            check($sformatf("row%0d miso idle", r), 32'(miso), 32'h0);
            if (vt[r].chk_rx) check($sformatf("row%0d miso stream", r), 32'(rx[15:0]), 32'(vt[r].rx));
        end

        // Second request lands inside the guard window and reloads the counter.
        s0 = n_strobe; seen_001 = 1'b0;
        send_frame(32'h1020, 16, rx);
        s1 = strobe_cyc;
        send_frame(32'h1060, 16, rx);
        s2 = strobe_cyc;
        clk_n(G + 20);
        check("reload strobes", 32'(n_strobe - s0), 32'd2);
        check("reload in guard", 32'((s2 - s1) < G), 32'd1);
        check("reload latency", 32'(chg_cyc - s2), 32'(G + 2));
        check("reload major", 32'(major_mode), 32'h3);
        check("reload never 001", 32'(seen_001), 32'h0);
        check("reload conf", 32'(conf_word[7:0]), 32'h60);

        // Reset mid-frame with ncs held low; the stale frame must be ignored.
        s0 = n_strobe;
        ncs = 1'b0;
        clk_n(4);
        shift_bits(32'h20, 8, rx);
        nrst = 1'b0;
        clk_n(3);
        nrst = 1'b1;
        clk_n(6);
        check("midrst conf", conf_word, 32'h0000_00E0);
        check("midrst major", 32'(major_mode), 32'h7);
        check("midrst valid", 32'(mode_valid), 32'h1);
        shift_bits(32'h2077, 16, rx);
        clk_n(4);
        ncs  = 1'b1;
        mosi = 1'b0;
        clk_n(8);
        check("midrst no strobe", 32'(n_strobe - s0), 32'd0);
        check("midrst no write", conf_word, 32'h0000_00E0);
        send_frame(32'h2077, 16, rx);
        clk_n(10);
        check("fresh strobe", 32'(n_strobe - s0), 32'd1);
        check("fresh conf", conf_word, 32'h0000_77E0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/hf_conf_rx.md
HF_CONF_RX -- requirements
Module: hf_conf_rx

Interface
REQ-001 Parameter WORD_W, default 16: SPI command length in bits.
REQ-002 Parameter OPC_W, default 4: opcode field width, taken from the top bits of the command.
REQ-003 Parameter NUM_REGS, default 4: number of 8-bit configuration registers.
REQ-004 Parameter GUARD_CYCLES, default 8: clock cycles with all modes off during a mode change.
REQ-005 Parameter SYNC_STAGES, default 2: synchroniser depth on spck, mosi and ncs.
REQ-006 ck_1356meg  in  1  sole clock; all logic on its rising edge.
REQ-007 nrst  in  1  reset, synchronous, active-low.
REQ-008 spck  in  1  SPI clock, asynchronous, oversampled.
REQ-009 mosi  in  1  SPI data in, MSB first.
REQ-010 ncs  in  1  SPI chip select, active-low.
REQ-011 miso  out  1  readback serial data.
REQ-012 conf_word  out  NUM_REGS*8  register file; register i is at bits [8i+7:8i].
REQ-013 major_mode  out  3  applied mode (3'b111 = off).
REQ-014 mode_valid  out  1  high when major_mode equals the requested mode.
REQ-015 cmd_strobe  out  1  one-cycle pulse for each accepted command.
REQ-016 frame_err  out  1  one-cycle pulse for each rejected frame.

Function
REQ-017 spck, mosi and ncs SHALL each pass through SYNC_STAGES flops; edge detection SHALL use the synchronised signals only.
REQ-018 On a synced spck rising edge with synced ncs low, shift_reg SHALL shift left, taking mosi into bit 0; the bit counter SHALL increment, saturating at WORD_W+1.
REQ-019 A synced ncs falling edge SHALL clear the bit counter.
REQ-020 A synced ncs rising edge with count == WORD_W SHALL decode opc = shift_reg[WORD_W-1 -: OPC_W]; any other count SHALL pulse frame_err and write nothing.
REQ-021 Opcode 1..NUM_REGS SHALL write register opc-1 with shift_reg[7:0].
REQ-022 Opcode NUM_REGS+1 SHALL set rd_sel = shift_reg[$clog2(NUM_REGS)-1:0] and write no register.
REQ-023 All other opcodes SHALL be ignored, with no frame_err.
REQ-024 cmd_strobe SHALL pulse for opcodes 1..NUM_REGS+1; register updates SHALL be visible in the cycle after the ncs edge detect.
REQ-025 A synced ncs falling edge SHALL load rb = {register rd_sel, zeros} (WORD_W bits); each synced spck falling edge with ncs low SHALL shift rb left; miso = rb[WORD_W-1]; miso SHALL be 0 while ncs is high.
REQ-026 The requested mode SHALL be register 0 bits [7:5].
REQ-027 Mode FSM states: RUN, GUARD, APPLY.
REQ-028 RUN: requested != major_mode -> GUARD, with major_mode <= 3'b111, mode_valid <= 0, guard counter <= GUARD_CYCLES-1.
REQ-029 GUARD: the counter decrements; a change in the requested mode SHALL reload it; at zero -> APPLY.
REQ-030 APPLY: major_mode <= current requested mode, mode_valid <= 1 -> RUN; one cycle.
REQ-031 A request equal to 3'b111 SHALL also take the GUARD path; major_mode SHALL never pass directly between two non-off modes.
REQ-032 A register write with the mode field unchanged SHALL NOT disturb the FSM.

Reset
REQ-033 nrst low SHALL set:
- registers: 8'hE0 for register 0, 8'h00 for the rest
- major_mode 3'b111, mode_valid 1, FSM in RUN
- shift_reg, counters, rd_sel and rb to 0; synchronisers to idle (ncs 1, spck 0)
- cmd_strobe, frame_err and miso to 0
REQ-034 A transfer in progress at reset SHALL be discarded; after reset the block SHALL ignore spck until a synced ncs rising edge has been seen (armed flag).
REQ-035 Reset during GUARD SHALL abandon the switch; major_mode stays 3'b111.

Structure
REQ-036 Package hf_conf_pkg SHALL hold MODE_OFF = 3'b111, the opcode constants and the FSM state enum.
REQ-037 Sub-module spi_sync SHALL be instantiated once per SPI input and provide the synchroniser plus rise/fall pulses.

Verification
REQ-038 Reset, write 16'h1040 -> cmd_strobe once; conf_word[7:0] = 8'h40; major_mode = 111 for 8 cycles, then 010 with mode_valid = 1.
REQ-039 Send a 15-bit frame, then a 17-bit frame -> frame_err pulses twice; conf_word unchanged.
REQ-040 Write 16'h3055, then 16'h5002, then a 16-bit read -> miso stream = 8'h55 followed by 8 zeros.
REQ-041 Request mode 001, then 011 after 4 guard cycles -> counter reloads; 011 applied 8 cycles after the second write; 001 never appears on major_mode.
REQ-042 Assert nrst mid-frame with ncs held low, then clock 16 bits -> no write and no strobe until ncs has gone high and a fresh frame is sent.
REQ-043 Write 16'h10E3 -> bits [7:5] still 111; no GUARD entry; mode_valid stays 1.
